// File: rtl/window_sequencer_if.sv
// rtl/window_sequencer_if.sv - pixel-strobe inputs and line-buffer/window control outputs of the 5x5 window sequencer
interface window_sequencer_if #(
  parameter int CW = 9
);
  logic          enable;
  logic          validin;
  logic          blanking_in;
  logic          lb_wr_en;
  logic [CW-1:0] lb_addr;
  logic          shift_en;
  logic          flush_zero;
  logic          border;
  logic          validout;
  logic          frame_start;
  logic          frame_done;
  logic          error;

  modport master (
    output enable, validin, blanking_in,
    input  lb_wr_en, lb_addr, shift_en, flush_zero, border, validout,
           frame_start, frame_done, error
  );

  modport slave (
    input  enable, validin, blanking_in,
    output lb_wr_en, lb_addr, shift_en, flush_zero, border, validout,
           frame_start, frame_done, error
  );
endinterface

// File: rtl/window_sequencer.sv
// rtl/window_sequencer.sv - frame row/column sequencing, line-buffer addressing and
// centre-valid/border timing for the 5x5 window stage, with a self-timed end-of-frame flush
module window_sequencer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int CW     = 9,
  parameter int RW     = 8
) (
  input  logic               clock,
  input  logic               reset,
  window_sequencer_if.slave  bus
);
  localparam int NW = CW + RW;
  localparam int FW = CW + 2;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_RGT  = CW'(WIDTH - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_BOT  = RW'(HEIGHT - 2);
  localparam logic [NW-1:0] IN_LAST  = NW'(WIDTH * HEIGHT - 1);
  localparam logic [NW-1:0] IN_LAG   = NW'(2 * WIDTH + 2);
  localparam logic [FW-1:0] FL_LAG   = FW'(2 * WIDTH + 2);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] col, col_n, ccol, ccol_n;
  logic [RW-1:0] row, row_n, crow, crow_n;
  logic [NW-1:0] in_cnt, in_cnt_n;
  logic [FW-1:0] fcnt, fcnt_n;

  logic          wr_q, wr_n, shift_q, shift_n, fz_q, fz_n, border_q, border_n;
  logic          vout_q, vout_n, fs_q, fs_n, fd_q, fd_n, err_q, err_n;
  logic [CW-1:0] addr_q, addr_n;
  logic          accept, ctr_adv;

  always_comb begin
    state_n  = state;
    col_n    = col;
    row_n    = row;
    in_cnt_n = in_cnt;
    ccol_n   = ccol;
    crow_n   = crow;
    fcnt_n   = fcnt;
    wr_n     = 1'b0;
    addr_n   = '0;
    shift_n  = 1'b0;
    fz_n     = 1'b0;
    border_n = 1'b0;
    vout_n   = 1'b0;
    fs_n     = 1'b0;
    fd_n     = 1'b0;
    err_n    = err_q;
    accept   = 1'b0;
    ctr_adv  = 1'b0;

    case (state)
      IDLE: begin
        // a pixel coinciding with the frame_done pulse belongs to no frame
        if (bus.enable && bus.validin && !bus.blanking_in && !fd_q) begin
          accept  = 1'b1;
          fs_n    = 1'b1;
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.blanking_in) begin
          err_n    = 1'b1;
          state_n  = IDLE;
          col_n    = '0;
          row_n    = '0;
          in_cnt_n = '0;
          ccol_n   = '0;
          crow_n   = '0;
        end else if (bus.validin) begin
          accept = 1'b1;
          if (in_cnt == IN_LAST) state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.validin) err_n = 1'b1;
        if (fcnt == FL_LAG) begin
          fd_n    = 1'b1;
          fcnt_n  = '0;
          state_n = IDLE;
        end else begin
          ctr_adv = 1'b1;
          shift_n = 1'b1;
          fz_n    = 1'b1;
          fcnt_n  = fcnt + FW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      wr_n    = 1'b1;
      addr_n  = col;
      shift_n = 1'b1;
      if (in_cnt >= IN_LAG) ctr_adv = 1'b1;
      if (in_cnt == IN_LAST) begin
        col_n    = '0;
        row_n    = '0;
        in_cnt_n = '0;
      end else begin
        in_cnt_n = in_cnt + NW'(1);
        if (col == COL_LAST) begin
          col_n = '0;
          row_n = row + RW'(1);
        end else begin
          col_n = col + CW'(1);
        end
      end
    end

    // centre position (crow, ccol) is the row/column split of the centre index
    if (ctr_adv) begin
      vout_n   = 1'b1;
      border_n = (crow < RW'(2)) || (crow >= ROW_BOT) || (ccol < CW'(2)) || (ccol >= COL_RGT);
      if (ccol == COL_LAST) begin
        ccol_n = '0;
        crow_n = (crow == ROW_LAST) ? '0 : crow + RW'(1);
      end else begin
        ccol_n = ccol + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      in_cnt   <= '0;
      ccol     <= '0;
      crow     <= '0;
      fcnt     <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      shift_q  <= 1'b0;
      fz_q     <= 1'b0;
      border_q <= 1'b0;
      vout_q   <= 1'b0;
      fs_q     <= 1'b0;
      fd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      row      <= row_n;
      in_cnt   <= in_cnt_n;
      ccol     <= ccol_n;
      crow     <= crow_n;
      fcnt     <= fcnt_n;
      wr_q     <= wr_n;
      addr_q   <= addr_n;
      shift_q  <= shift_n;
      fz_q     <= fz_n;
      border_q <= border_n;
      vout_q   <= vout_n;
      fs_q     <= fs_n;
      fd_q     <= fd_n;
      err_q    <= err_n;
    end
  end

  assign bus.lb_wr_en    = wr_q;
  assign bus.lb_addr     = addr_q;
  assign bus.shift_en    = shift_q;
  assign bus.flush_zero  = fz_q;
  assign bus.border      = border_q;
  assign bus.validout    = vout_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done  = fd_q;
  assign bus.error       = err_q;
endmodule

// File: tb/tb_window_sequencer.sv
// tb/tb_window_sequencer.sv - directed frame-level bench for window_sequencer on an 8x6 frame
module tb_window_sequencer;
  localparam int W = 8;
  localparam int H = 6;

  logic clock;
  logic reset;

  window_sequencer_if #(.CW(4)) bus ();

  window_sequencer #(.WIDTH(W), .HEIGHT(H), .CW(4), .RW(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec, n_err;
  int n_wr, n_vout, n_border, n_fz, n_shift, n_fd, n_fs, first_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_border(input int idx);
    int cr, cc;
    cr = idx / W;
    cc = idx % W;
    return (cr < 2) || (cr >= H - 2) || (cc < 2) || (cc >= W - 2);
  endfunction

  function automatic logic [31:0] all_outs();
    return {20'd0, bus.lb_wr_en, bus.lb_addr, bus.shift_en, bus.flush_zero, bus.border,
            bus.validout, bus.frame_start, bus.frame_done, bus.error};
  endfunction

  task automatic clear_stats();
    n_wr = 0; n_vout = 0; n_border = 0; n_fz = 0;
    n_shift = 0; n_fd = 0; n_fs = 0; first_wr = 0;
  endtask

  // one clock: drive inputs, then sample the registered response just after the edge
  task automatic cycle(input logic v, input logic b);
    bus.validin     = v;
    bus.blanking_in = b;
    @(posedge clock);
    #1;
    if (bus.lb_wr_en) begin
      chk("lb_addr", {28'd0, bus.lb_addr}, n_wr % W);
      n_wr++;
    end
    if (bus.validout) begin
      if (n_vout == 0) first_wr = n_wr;
      chk("border", {31'd0, bus.border}, {31'd0, exp_border(n_vout)});
      n_border += bus.border;
      n_vout++;
    end else if (bus.border) begin
      chk("border_idle", 32'd1, 32'd0);
    end
    if (bus.flush_zero) begin
      chk("flush_outs", {29'd0, bus.validout, bus.shift_en, bus.lb_wr_en}, 32'd6);
      n_fz++;
    end
    n_shift += bus.shift_en;
    n_fs    += bus.frame_start;
    if (bus.frame_done) begin
      chk("done_after_flush", n_vout, W * H);
      n_fd++;
    end
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < W * H; i++) begin
      cycle(1'b1, 1'b0);
      repeat (gap) cycle(1'b0, 1'b0);
    end
  endtask

  task automatic wait_done(input logic b);
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, b);
      if (bus.frame_done) break;
    end
  endtask

  task automatic check_frame();
    chk("wr_count", n_wr, W * H);
    chk("vout_count", n_vout, W * H);
    chk("first_vout_after_pixel", first_wr, 2 * W + 3);
    chk("flush_cycles", n_fz, 2 * W + 2);
    chk("border_count", n_border, 40);
    chk("frame_done_count", n_fd, 1);
    chk("frame_start_count", n_fs, 1);
    chk("shift_count", n_shift, W * H + 2 * W + 2);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_stats();
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.validin     = 1'b0;
    bus.blanking_in = 1'b1;
    #2 reset = 1'b0;
    #1 chk("reset_outputs", all_outs(), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) cycle(1'b0, 1'b1);

    // disabled: pixels ignored without error
    repeat (5) cycle(1'b1, 1'b0);
    chk("disabled_wr", n_wr, 0);
    chk("disabled_start", n_fs, 0);
    chk("disabled_error", {31'd0, bus.error}, 32'd0);

    // contiguous frame
    bus.enable = 1'b1;
    repeat (2) cycle(1'b0, 1'b1);
    clear_stats();
    send_frame(0);
    wait_done(1'b0);
    check_frame();
    chk("contig_error", {31'd0, bus.error}, 32'd0);

    // one pixel every third cycle
    repeat (3) cycle(1'b0, 1'b1);
    clear_stats();
    send_frame(2);
    wait_done(1'b0);
    check_frame();
    chk("gapped_error", {31'd0, bus.error}, 32'd0);

    // stray pixel during flush
    repeat (3) cycle(1'b0, 1'b1);
    clear_stats();
    send_frame(0);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    wait_done(1'b0);
    check_frame();
    chk("flush_validin_error", {31'd0, bus.error}, 32'd1);

    // asynchronous reset mid-frame
    repeat (3) cycle(1'b0, 1'b1);
    clear_stats();
    repeat (10) cycle(1'b1, 1'b0);
    #3 reset = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) cycle(1'b0, 1'b1);
    clear_stats();
    send_frame(0);
    wait_done(1'b0);
    check_frame();
    chk("after_reset_error", {31'd0, bus.error}, 32'd0);

    // blanking abort after 20 pixels
    clear_stats();
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    wait_done(1'b1);
    chk("abort_error", {31'd0, bus.error}, 32'd1);
    chk("abort_no_done", n_fd, 0);
    chk("abort_vout", n_vout, 2);
    chk("abort_wr", n_wr, 20);
    clear_stats();
    send_frame(0);
    wait_done(1'b0);
    check_frame();
    chk("abort_error_sticky", {31'd0, bus.error}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
